bus_reg_bank: RTL and testbench

//   Parametrised general-purpose register bank with integrated one-hot bus

---
 rtl/bus_reg_bank.sv | 147 ++++++++++++++
 tb/tb_bus_reg_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_reg_bank.sv
// rtl/bus_reg_bank.sv - parametrised register bank with one-hot bus source selection
module bus_reg_bank #(
  parameter int unsigned  WIDTH    = 32,
  parameter int unsigned  NUM_REGS = 16,
  parameter int unsigned  NUM_EXT  = 8,
  parameter bit           R0_ZERO  = 1'b1,
  parameter bit           BUS_PIPE = 1'b0,
  localparam int unsigned NSRC     = NUM_REGS + NUM_EXT,
  localparam int unsigned AW       = $clog2(NUM_REGS),
  localparam int unsigned IW       = $clog2(NSRC)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_REGS-1:0]      reg_in_en,
  input  logic [NUM_REGS-1:0]      reg_out_sel,
  input  logic [NUM_EXT-1:0]       ext_sel,
  input  logic [WIDTH*NUM_EXT-1:0] ext_data,
  input  logic                     ba_out,
  input  logic                     err_clr,
  input  logic [AW-1:0]            dbg_addr,
  output logic [WIDTH-1:0]         bus_data,
  output logic                     bus_valid,
  output logic [IW-1:0]            src_idx,
  output logic                     sel_err,
  output logic [WIDTH-1:0]         dbg_data
);

  logic [WIDTH-1:0] regs_q  [NUM_REGS];
  logic [WIDTH-1:0] regs_d  [NUM_REGS];
  logic [WIDTH-1:0] src_val [NSRC];
  logic [NSRC-1:0]  sel_vec;
  logic [WIDTH-1:0] pick_val;
  logic [IW-1:0]    pick_idx;
  logic             sel_any;
  logic             sel_multi;
  logic             sel_one;
  logic [WIDTH-1:0] sel_data;
  logic [IW-1:0]    sel_idx;
  logic             sel_err_q;
  logic             sel_err_d;

  // Registers occupy source positions 0..NUM_REGS-1, external sources follow.
  assign sel_vec = {ext_sel, reg_out_sel};

  // Gather every bus source into one indexable array; R0 is masked in base-address mode.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      src_val[i] = regs_q[i];
    end
    if (R0_ZERO && ba_out) begin
      src_val[0] = '0;
    end
    for (int k = 0; k < NUM_EXT; k++) begin
      src_val[NUM_REGS + k] = ext_data[k*WIDTH +: WIDTH];
    end
  end

  // Scan the selects: remember the selected source and whether a second one also fired.
  always_comb begin
    sel_any   = 1'b0;
    sel_multi = 1'b0;
    pick_val  = '0;
    pick_idx  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel_vec[i]) begin
        sel_multi = sel_multi | sel_any;
        sel_any   = 1'b1;
        pick_val  = src_val[i];
        pick_idx  = IW'(i);
      end
    end
  end

  // Only a single driver produces a valid bus; none or several collapse to zero.
  assign sel_one  = sel_any & ~sel_multi;
  assign sel_data = sel_one ? pick_val : '0;
  assign sel_idx  = sel_one ? pick_idx : '0;

  generate
    if (BUS_PIPE) begin : g_pipe
      logic [WIDTH-1:0] bus_q;
      logic             valid_q;
      logic [IW-1:0]    idx_q;

      // Bus stage register; a clear drops whatever value was in flight.
      always_ff @(posedge clk) begin
        if (clr) begin
          bus_q   <= '0;
          valid_q <= 1'b0;
          idx_q   <= '0;
        end else begin
          bus_q   <= sel_data;
          valid_q <= sel_one;
          idx_q   <= sel_idx;
        end
      end

      assign bus_data  = bus_q;
      assign bus_valid = valid_q;
      assign src_idx   = idx_q;
    end else begin : g_comb
      assign bus_data  = sel_data;
      assign bus_valid = sel_one;
      assign src_idx   = sel_idx;
    end
  endgenerate

  // An enabled register takes the bus only when the bus is valid; otherwise it holds.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (reg_in_en[i] && bus_valid) ? bus_data : regs_q[i];
    end
  end

  // Register storage; clear wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_q[i] <= clr ? '0 : regs_d[i];
    end
  end

  // Sticky multi-driver flag: a fresh conflict wins over err_clr.
  always_comb begin
    sel_err_d = sel_err_q;
    if (sel_multi) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    sel_err_q <= clr ? 1'b0 : sel_err_d;
  end

  assign sel_err = sel_err_q;

  // Raw debug view of storage, independent of ba_out; out-of-range addresses read zero.
  always_comb begin
    dbg_data = '0;
    if (32'(dbg_addr) < NUM_REGS) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb/tb_bus_reg_bank.sv - scoreboard bench for bus_reg_bank in three configurations
module tb_bus_reg_bank;

  logic         clk;
  logic         clr;
  logic [15:0]  reg_in_en;
  logic [15:0]  reg_out_sel;
  logic [7:0]   ext_sel;
  logic [255:0] ext_data;
  logic         ba_out;
  logic         err_clr;
  logic [3:0]   dbg_addr;
  logic [47:0]  ext_s;

  logic [31:0] c_bus, c_dbg, p_bus, p_dbg;
  logic        c_valid, c_err, p_valid, p_err;
  logic [4:0]  c_idx, p_idx;
  logic [15:0] s_bus, s_dbg;
  logic        s_valid, s_err;
  logic [3:0]  s_idx;

  int n_pass;
  int n_total;

  // Small bank sees the low 16 bits of external words 0..2.
  assign ext_s = {ext_data[79:64], ext_data[47:32], ext_data[15:0]};

  bus_reg_bank #(.WIDTH(32), .NUM_REGS(16), .NUM_EXT(8), .R0_ZERO(1'b1), .BUS_PIPE(1'b0)) u_c (
    .clk(clk), .clr(clr), .reg_in_en(reg_in_en), .reg_out_sel(reg_out_sel),
    .ext_sel(ext_sel), .ext_data(ext_data), .ba_out(ba_out), .err_clr(err_clr),
    .dbg_addr(dbg_addr), .bus_data(c_bus), .bus_valid(c_valid), .src_idx(c_idx),
    .sel_err(c_err), .dbg_data(c_dbg));

  bus_reg_bank #(.WIDTH(32), .NUM_REGS(16), .NUM_EXT(8), .R0_ZERO(1'b1), .BUS_PIPE(1'b1)) u_p (
    .clk(clk), .clr(clr), .reg_in_en(reg_in_en), .reg_out_sel(reg_out_sel),
    .ext_sel(ext_sel), .ext_data(ext_data), .ba_out(ba_out), .err_clr(err_clr),
    .dbg_addr(dbg_addr), .bus_data(p_bus), .bus_valid(p_valid), .src_idx(p_idx),
    .sel_err(p_err), .dbg_data(p_dbg));

  bus_reg_bank #(.WIDTH(16), .NUM_REGS(8), .NUM_EXT(3), .R0_ZERO(1'b0), .BUS_PIPE(1'b0)) u_s (
    .clk(clk), .clr(clr), .reg_in_en(reg_in_en[7:0]), .reg_out_sel(reg_out_sel[7:0]),
    .ext_sel(ext_sel[2:0]), .ext_data(ext_s), .ba_out(ba_out), .err_clr(err_clr),
    .dbg_addr(dbg_addr[2:0]), .bus_data(s_bus), .bus_valid(s_valid), .src_idx(s_idx),
    .sel_err(s_err), .dbg_data(s_dbg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c_bus; logic c_valid; logic [4:0] c_idx; logic c_err; logic [31:0] c_dbg;
    logic [31:0] p_bus; logic p_valid; logic [4:0] p_idx; logic p_err; logic [31:0] p_dbg;
    logic [15:0] s_bus; logic s_valid; logic [3:0] s_idx; logic s_err; logic [15:0] s_dbg;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: register contents per bank, bus stage of the piped bank, error flags.
  logic [31:0] mc [16];
  logic [31:0] mp [16];
  logic [15:0] ms [8];
  logic [31:0] pm_bus;
  logic        pm_valid;
  logic [4:0]  pm_idx;
  logic        err_b;
  logic        err_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic int lowest(input logic [23:0] v);
    for (int i = 0; i < 24; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] big_src(input bit use_p, input int idx);
    if (idx < 16) begin
      if (idx == 0 && ba_out) return 32'h0;
      return use_p ? mp[idx] : mc[idx];
    end
    return ext_data[(idx-16)*32 +: 32];
  endfunction

  // One stimulus cycle: predict outputs for the current inputs, then advance the model across the edge.
  task automatic tick();
    exp_t e;
    logic [23:0] sb;
    logic [10:0] ss;
    int nb, ns, ib, is_;
    logic [31:0] vc, vp;
    logic [15:0] vs;
    sb = {ext_sel, reg_out_sel};
    ss = {ext_sel[2:0], reg_out_sel[7:0]};
    nb = $countones(sb);
    ns = $countones(ss);
    ib = lowest(sb);
    is_ = lowest({13'b0, ss});
    vc = big_src(1'b0, ib);
    vp = big_src(1'b1, ib);
    if (is_ < 8) vs = ms[is_];
    else vs = ext_data[(is_-8)*32 +: 16];

    e.c_bus = (nb == 1) ? vc : 32'h0;
    e.c_valid = (nb == 1);
    e.c_idx = (nb == 1) ? 5'(ib) : 5'd0;
    e.c_err = err_b;
    e.c_dbg = mc[dbg_addr];
    e.p_bus = pm_bus;
    e.p_valid = pm_valid;
    e.p_idx = pm_idx;
    e.p_err = err_b;
    e.p_dbg = mp[dbg_addr];
    e.s_bus = (ns == 1) ? vs : 16'h0;
    e.s_valid = (ns == 1);
    e.s_idx = (ns == 1) ? 4'(is_) : 4'd0;
    e.s_err = err_s;
    e.s_dbg = ms[dbg_addr[2:0]];
    exp_q.push_back(e);

    if (clr) begin
      for (int i = 0; i < 16; i++) begin mc[i] = 0; mp[i] = 0; end
      for (int i = 0; i < 8; i++) ms[i] = 0;
      pm_bus = 0; pm_valid = 0; pm_idx = 0; err_b = 0; err_s = 0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (reg_in_en[i] && nb == 1) mc[i] = vc;
        if (reg_in_en[i] && pm_valid) mp[i] = pm_bus;
      end
      for (int i = 0; i < 8; i++) if (reg_in_en[i] && ns == 1) ms[i] = vs;
      pm_bus = (nb == 1) ? vp : 32'h0;
      pm_valid = (nb == 1);
      pm_idx = (nb == 1) ? 5'(ib) : 5'd0;
      if (nb > 1) err_b = 1'b1; else if (err_clr) err_b = 1'b0;
      if (ns > 1) err_s = 1'b1; else if (err_clr) err_s = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_in_en = '0; reg_out_sel = '0; ext_sel = '0; err_clr = 1'b0; clr = 1'b0; ba_out = 1'b0;
  endtask

  task automatic set_src(input int s);
    if (s < 16) reg_out_sel[s] = 1'b1;
    else ext_sel[s-16] = 1'b1;
  endtask

  // Two cycles so both the combinational and the piped bank complete the load.
  task automatic load(input int r, input logic [31:0] v);
    idle();
    ext_sel[0] = 1'b1; ext_data[31:0] = v; reg_in_en[r] = 1'b1;
    tick(); tick();
    idle();
  endtask

  // Monitor: compares the DUT against the oldest outstanding expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("c_bus", c_bus, e.c_bus);
        chk("c_valid", 32'(c_valid), 32'(e.c_valid));
        chk("c_idx", 32'(c_idx), 32'(e.c_idx));
        chk("c_err", 32'(c_err), 32'(e.c_err));
        chk("c_dbg", c_dbg, e.c_dbg);
        chk("p_bus", p_bus, e.p_bus);
        chk("p_valid", 32'(p_valid), 32'(e.p_valid));
        chk("p_idx", 32'(p_idx), 32'(e.p_idx));
        chk("p_err", 32'(p_err), 32'(e.p_err));
        chk("p_dbg", p_dbg, e.p_dbg);
        chk("s_bus", 32'(s_bus), 32'(e.s_bus));
        chk("s_valid", 32'(s_valid), 32'(e.s_valid));
        chk("s_idx", 32'(s_idx), 32'(e.s_idx));
        chk("s_err", 32'(s_err), 32'(e.s_err));
        chk("s_dbg", 32'(s_dbg), 32'(e.s_dbg));
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    ext_data = '0; dbg_addr = '0;
    idle();
    for (int i = 0; i < 16; i++) begin mc[i] = 0; mp[i] = 0; end
    for (int i = 0; i < 8; i++) ms[i] = 0;
    pm_bus = 0; pm_valid = 0; pm_idx = 0; err_b = 0; err_s = 0;

    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    tick();

    // External source 1 into R5, then read R5 back.
    idle(); ext_sel[1] = 1'b1; ext_data[63:32] = 32'hDEADBEEF; reg_in_en[5] = 1'b1;
    tick(); tick();
    idle(); dbg_addr = 4'd5; tick();

    // R0 masked only on the bus in base-address mode.
    load(0, 32'h1234);
    dbg_addr = 4'd0; reg_out_sel[0] = 1'b1; ba_out = 1'b1; tick(); tick();
    ba_out = 1'b0; tick(); tick();

    // Double select: no write, sticky error, set beats err_clr.
    idle(); reg_out_sel[2] = 1'b1; reg_out_sel[3] = 1'b1; reg_in_en[4] = 1'b1; dbg_addr = 4'd4;
    tick();
    idle(); tick(); tick();
    reg_out_sel[2] = 1'b1; reg_out_sel[3] = 1'b1; err_clr = 1'b1; tick();
    idle(); err_clr = 1'b1; tick();
    idle(); tick();

    // Register-to-register transfer with the select one cycle ahead of the enable.
    load(2, 32'h55);
    reg_out_sel[2] = 1'b1; tick();
    idle(); reg_in_en[7] = 1'b1; dbg_addr = 4'd7; tick();
    idle(); tick();
    ext_sel[3] = 1'b1; ext_data[127:96] = 32'hAA; reg_in_en[7] = 1'b1; tick();
    idle(); tick();

    // Fill R1..R15, then clear with every enable asserted.
    for (int r = 1; r < 16; r++) load(r, 32'h100 + 32'(r) * 32'h01010101);
    reg_in_en = '1; ext_sel[0] = 1'b1; ext_data[31:0] = 32'hFFFF; clr = 1'b1; tick();
    idle();
    for (int a = 0; a < 16; a++) begin dbg_addr = 4'(a); tick(); end

    // Walking ones through every source position.
    for (int s = 0; s < 24; s++) begin
      idle(); set_src(s);
      for (int k = 0; k < 8; k++) ext_data[k*32 +: 32] = 32'hE0000000 | 32'(k);
      tick();
    end
    idle(); tick();

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      int mode, r, a;
      idle();
      mode = $urandom_range(0, 9);
      if (mode == 1) begin
        a = $urandom_range(0, 23);
        set_src(a);
        set_src((a + 1 + $urandom_range(0, 22)) % 24);
      end else if (mode != 0) begin
        set_src($urandom_range(0, 23));
      end
      r = $urandom_range(0, 3);
      if (r == 1 || r == 2) reg_in_en[$urandom_range(0, 15)] = 1'b1;
      else if (r == 3) reg_in_en = 16'($urandom);
      for (int k = 0; k < 8; k++) ext_data[k*32 +: 32] = $urandom;
      ba_out = 1'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 49) == 0);
      dbg_addr = 4'($urandom_range(0, 15));
      tick();
    end
    idle(); tick();

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
